// File: rtl/data_interpolation.sv
// Upsampler: each accepted sample is replayed as interpolate_reg+1 output beats.
// Zero-order hold by default; define ZERO_STUFF_EN to emit zeros on beats 1..N.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   interpolate_reg         extra beats per sample (N), sampled on input accept
//   in_data/_valid/_ready   input sample stream (valid/ready)
//   out_data/_valid/_ready  output beat stream (valid/ready)
//   out_data_last           final beat of the current sample's burst
// Macro: ZERO_STUFF_EN selects zero-stuffing instead of zero-order hold.
module data_interpolation #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 12,
    parameter int DATA_REG_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_REG_WIDTH-1:0] interpolate_reg,
    input  logic [DATA_IN_WIDTH-1:0]  in_data,
    input  logic                      in_data_valid,
    output logic                      in_data_ready,
    output logic [DATA_OUT_WIDTH-1:0] out_data,
    output logic                      out_data_valid,
    input  logic                      out_data_ready,
    output logic                      out_data_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam logic [DATA_REG_WIDTH-1:0] ONE = DATA_REG_WIDTH'(1);

    state_e                    state_q, state_d;
    logic [DATA_REG_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_REG_WIDTH-1:0] n_lat_q, n_lat_d;
    logic [DATA_IN_WIDTH-1:0]  hold_q, hold_d;

    logic                      emit;
    logic                      at_last;
    logic                      accept;
    logic [DATA_OUT_WIDTH-1:0] sample_msb;
    logic                      unused_hold_bits;

    assign emit       = (state_q == EMIT);
    // Compare before increment: with N at its maximum the counter
    // reaches N and stops there, so it can never wrap mid-burst.
    assign at_last    = (cnt_q == n_lat_q);
    assign sample_msb = hold_q[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH];

    // Only the MSBs reach the output; the rest are intentionally dropped.
    assign unused_hold_bits = ^hold_q;

    // Combinational path from out_data_ready lets a new sample be taken
    // on the same cycle the last beat leaves, so bursts abut without gaps.
    assign in_data_ready = rst_n &&
                           (!emit || (at_last && out_data_ready));
    assign accept        = in_data_valid && in_data_ready;

    assign out_data_valid = emit;
    assign out_data_last  = emit && at_last;

`ifdef ZERO_STUFF_EN
    assign out_data = (emit && cnt_q == '0) ? sample_msb : '0;
`else
    assign out_data = emit ? sample_msb : '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_lat_d = n_lat_q;
        hold_d  = hold_q;
        if (accept) begin
            state_d = EMIT;
            cnt_d   = '0;
            n_lat_d = interpolate_reg;
            hold_d  = in_data;
        end else if (emit && out_data_ready) begin
            if (at_last) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_lat_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_lat_q <= n_lat_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_data_interpolation.sv
// Self-checking bench for data_interpolation: directed scenarios plus a
// randomized run against a queue-based beat model.
module tb_data_interpolation;

    localparam int IW = 16;
    localparam int OW = 12;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] nreg;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_interpolation #(
        .DATA_IN_WIDTH (IW),
        .DATA_OUT_WIDTH(OW),
        .DATA_REG_WIDTH(RW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .interpolate_reg(nreg),
        .in_data        (in_data),
        .in_data_valid  (in_valid),
        .in_data_ready  (in_ready),
        .out_data       (out_data),
        .out_data_valid (out_valid),
        .out_data_ready (out_ready),
        .out_data_last  (out_last)
    );

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];

    // Expected content of beat k of a sample's burst.
    function automatic logic [OW-1:0] exp_beat(logic [IW-1:0] s, int k);
`ifdef ZERO_STUFF_EN
        if (k != 0) return '0;
`endif
        return s[IW-1 -: OW];
    endfunction

    // Scoreboard: each accepted sample expands into N+1 expected beats;
    // the remaining-beat count also predicts in_data_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            tests++;
            if (out_valid !== (exp_q.size() != 0)) begin
                fails++;
                $display("FAIL sb_valid: got %b want %b", out_valid, exp_q.size() != 0);
            end
            tests++;
            if (in_ready !== (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready))) begin
                fails++;
                $display("FAIL sb_ready: got %b pending %0d", in_ready, exp_q.size());
            end
            if (out_valid && exp_q.size() != 0) begin
                tests++;
                if (out_data !== exp_q[0].data || out_last !== exp_q[0].last) begin
                    fails++;
                    $display("FAIL sb_beat: got %h/%b want %h/%b",
                             out_data, out_last, exp_q[0].data, exp_q[0].last);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k <= int'(nreg); k++) begin
                    exp_q.push_back('{data: exp_beat(in_data, k), last: (k == int'(nreg))});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; nreg = '0;
        #3;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: v=%b d=%h l=%b r=%b", out_valid, out_data, out_last, in_ready);
        end
        repeat (3) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: r=%b v=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_zoh_burst();
        logic [IW-1:0] s[2];
        logic [OW-1:0] d[8];
        logic          l[8], v[8], r[8];
        int            acc = 0;
        s[0] = 16'hABC0; s[1] = 16'h1230;
        nreg = 3; out_ready = 1'b1;
        cyc();
        in_valid = 1'b1; in_data = s[0];
        @(negedge clk);
        if (in_valid && in_ready) acc++;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (acc == 1) in_data = s[1];
            else if (acc >= 2) in_valid = 1'b0;
            @(negedge clk);
            d[c-1] = out_data; l[c-1] = out_last;
            v[c-1] = out_valid; r[c-1] = in_ready;
            if (in_valid && in_ready) acc++;
        end
        cyc(); in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (v[i] !== 1'b1 || d[i] !== exp_beat(s[i/4], i%4) || l[i] !== (i%4 == 3)) begin
                fails++;
                $display("FAIL zoh_beat%0d: got %b/%h/%b want 1/%h/%b",
                         i, v[i], d[i], l[i], exp_beat(s[i/4], i%4), i%4 == 3);
            end
            tests++;
            if (r[i] !== (i == 3 || i == 7)) begin
                fails++;
                $display("FAIL zoh_ready%0d: got %b want %b", i, r[i], i == 3 || i == 7);
            end
        end
    endtask

    task automatic test_passthrough();
        logic [IW-1:0] s[8];
        for (int i = 0; i < 8; i++) s[i] = IW'($urandom);
        nreg = 0; out_ready = 1'b1;
        cyc();
        in_valid = 1'b1; in_data = s[0];
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL pass_ready%0d: got %b want 1", c, in_ready);
            end
            cyc();
            if (c < 8) in_data = s[c];
            else in_valid = 1'b0;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== s[c-1][IW-1 -: OW] || out_last !== 1'b1) begin
                fails++;
                $display("FAIL pass_beat%0d: got %b/%h/%b want 1/%h/1",
                         c, out_valid, out_data, out_last, s[c-1][IW-1 -: OW]);
            end
        end
        cyc();
    endtask

    task automatic test_backpressure();
        int            acc = 0, beats = 0, guard = 0;
        logic          pv = 1'b0, pr = 1'b1, pl = 1'b0;
        logic [OW-1:0] pd = '0;
        nreg = 2;
        for (int c = 0; c < 60 || out_valid; c++) begin
            cyc();
            in_valid  = (c < 60);
            in_data   = IW'($urandom);
            out_ready = (c >= 60) || (c % 3 == 0);
            @(negedge clk);
            if (pv && !pr) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    fails++;
                    $display("FAIL bp_stall: got %b/%h/%b want 1/%h/%b",
                             out_valid, out_data, out_last, pd, pl);
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) beats++;
            guard++;
            if (guard > 400) break;
        end
        in_valid = 1'b0;
        tests++;
        if (beats !== 3 * acc || acc == 0) begin
            fails++;
            $display("FAIL bp_count: beats %0d samples %0d want %0d", beats, acc, 3 * acc);
        end
    endtask

    task automatic test_reconfig();
        int lens[$];
        int run = 0, acc = 0;
        logic [IW-1:0] s[2];
        s[0] = IW'($urandom); s[1] = IW'($urandom);
        nreg = 1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b1; in_data = s[0];
        @(negedge clk);
        if (in_valid && in_ready) acc++;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (c == 1) nreg = 4;
            if (acc == 1) in_data = s[1];
            else if (acc >= 2) in_valid = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) begin
                run++;
                if (out_last) begin
                    lens.push_back(run);
                    run = 0;
                end
            end
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0;
        tests++;
        if (lens.size() != 2 || lens[0] != 2 || lens[1] != 5) begin
            fails++;
            $display("FAIL reconfig_len: got %0d bursts first %0d second %0d want 2/5",
                     lens.size(), lens.size() > 0 ? lens[0] : -1,
                     lens.size() > 1 ? lens[1] : -1);
        end
        nreg = 0;
    endtask

    task automatic test_mode_n2();
        logic [IW-1:0] s;
        s = 16'h7FF0;
        nreg = 2; out_ready = 1'b1;
        cyc();
        in_valid = 1'b1; in_data = s;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cyc(); in_valid = 1'b0;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(s, k) || out_last !== (k == 2)) begin
                fails++;
                $display("FAIL mode_beat%0d: got %b/%h/%b want 1/%h/%b",
                         k, out_valid, out_data, out_last, exp_beat(s, k), k == 2);
            end
        end
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        nreg = 3; out_ready = 1'b1;
        cyc();
        in_valid = 1'b1; in_data = IW'($urandom);
        @(negedge clk);
        repeat (2) begin
            cyc(); in_valid = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: v=%b d=%h r=%b want 0/000/0", out_valid, out_data, in_ready);
        end
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_resume%0d: valid %b want 0", c, out_valid);
            end
            cyc();
        end
        in_valid = 1'b1; in_data = 16'h1230;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            cyc(); in_valid = 1'b0;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(16'h1230, k) || out_last !== (k == 3)) begin
                fails++;
                $display("FAIL rst_fresh%0d: got %b/%h/%b want 1/%h/%b",
                         k, out_valid, out_data, out_last, exp_beat(16'h1230, k), k == 3);
            end
        end
        cyc();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = IW'($urandom);
                nreg     = RW'($urandom_range(0, 4));
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 50 && out_valid; c++) cyc();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || exp_queue_len() != 0) begin
            fails++;
            $display("FAIL rand_drain: valid %b pending %0d want 0/0", out_valid, exp_queue_len());
        end
    endtask

    function automatic int exp_queue_len();
        return exp_q.size();
    endfunction

    initial begin
        test_reset();
        test_zoh_burst();
        test_passthrough();
        test_backpressure();
        test_reconfig();
        test_mode_n2();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1);
    end

endmodule
